crosswalk_request_ctrl: RTL and testbench

Upstream stage of the two-way intersection controller. It conditions the two raw pedestrian push-buttons with a synchroniser and a debouncer, latches each press as a request, and drives the crosswalk request inputs of the intersection controller. It also consumes that controller's green-light outputs to sequence per-crosswalk WALK and flashing DON'T-WALK pedestrian signals.

---
 rtl/crosswalk_pkg.sv | 22 ++
 rtl/crosswalk_request_ctrl_if.sv | 37 +++
 rtl/crosswalk_debounce.sv | 59 +++++
 rtl/crosswalk_request_ctrl.sv | 155 +++++++++++++++
 tb/tb_crosswalk_request_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/crosswalk_pkg.sv
// ---------------------------------------------------------------------------
// crosswalk_pkg
// Shared definitions for the crosswalk request controller:
//   - walk_state_e : per-channel pedestrian FSM encoding (2 bits)
//   - DEF_*        : default timing constants used as parameter defaults
// ---------------------------------------------------------------------------
package crosswalk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WALK  = 2'd2,
    ST_FLASH = 2'd3
  } walk_state_e;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_WALK_TON   = 12;
  localparam int DEF_FLASH_TON  = 6;
  localparam int DEF_FLASH_DIV  = 2;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/crosswalk_request_ctrl_if.sv
// ---------------------------------------------------------------------------
// crosswalk_request_ctrl_if
// Groups the pedestrian-side and intersection-side signals of the crosswalk
// request controller.
//   btn_0/btn_1             : raw push-buttons (asynchronous, may bounce)
//   grn_0/grn_1             : green indications from the intersection
//   crosswalk_0/crosswalk_1 : latched requests to the intersection
//   walk_0/walk_1           : WALK lamps
//   flash_0/flash_1         : flashing DON'T-WALK lamps
// Modports:
//   master : environment side (drives buttons and greens)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface crosswalk_request_ctrl_if;

  logic btn_0;
  logic btn_1;
  logic grn_0;
  logic grn_1;
  logic crosswalk_0;
  logic crosswalk_1;
  logic walk_0;
  logic walk_1;
  logic flash_0;
  logic flash_1;

  modport master (
    output btn_0, btn_1, grn_0, grn_1,
    input  crosswalk_0, crosswalk_1, walk_0, walk_1, flash_0, flash_1
  );

  modport slave (
    input  btn_0, btn_1, grn_0, grn_1,
    output crosswalk_0, crosswalk_1, walk_0, walk_1, flash_0, flash_1
  );

endinterface

// File: rtl/crosswalk_debounce.sv
// ---------------------------------------------------------------------------
// crosswalk_debounce
// Conditions one raw push-button: two-flop synchroniser, counting debouncer
// and a one-cycle press pulse on the rising edge of the debounced level.
// Ports:
//   clk     : clock, posedge
//   reset_n : asynchronous reset, active-high
//   i_btn   : raw asynchronous button
//   o_press : one-cycle pulse when the debounced level rises
// ---------------------------------------------------------------------------
module crosswalk_debounce
  import crosswalk_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_debD;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the button, then only flip the debounced level once the
  // synchronised input has disagreed with it for DEB_CYCLES cycles in a row.
  // Any agreement in between restarts the count, so short glitches vanish.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_debD  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_debD  <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_press = r_deb & ~r_debD;

endmodule

// File: rtl/crosswalk_request_ctrl.sv
// ---------------------------------------------------------------------------
// crosswalk_request_ctrl
// Upstream stage of the two-way intersection controller. For each of the two
// crosswalks it debounces the push-button, latches a request for the
// intersection and sequences the WALK / flashing DON'T-WALK lamps from the
// intersection's green indication.
// Ports:
//   clk     : clock, posedge
//   reset_n : asynchronous reset, active-high
//   bus     : crosswalk_request_ctrl_if.slave (buttons, greens, requests,
//             walk and flash lamps for channels 0 and 1)
// ---------------------------------------------------------------------------
module crosswalk_request_ctrl
  import crosswalk_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int WALK_TON   = DEF_WALK_TON,
  parameter int FLASH_TON  = DEF_FLASH_TON,
  parameter int FLASH_DIV  = DEF_FLASH_DIV,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  crosswalk_request_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TON - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TON - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(FLASH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0] w_btn;
  logic [1:0] w_grn;
  logic [1:0] w_cross;
  logic [1:0] w_walk;
  logic [1:0] w_flash;

  assign w_btn = {bus.btn_1, bus.btn_0};
  assign w_grn = {bus.grn_1, bus.grn_0};

  assign bus.crosswalk_0 = w_cross[0];
  assign bus.crosswalk_1 = w_cross[1];
  assign bus.walk_0      = w_walk[0];
  assign bus.walk_1      = w_walk[1];
  assign bus.flash_0     = w_flash[0];
  assign bus.flash_1     = w_flash[1];

  for (genvar g = 0; g < 2; g++) begin : gen_chan

    logic             w_press;
    logic             w_grnRise;
    logic             w_serve;
    logic             r_grnD;
    logic             r_req;
    logic             r_walk;
    logic             r_flash;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_div;
    walk_state_e      r_state;

    crosswalk_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_btn   (w_btn[g]),
      .o_press (w_press)
    );

    // Only a fresh green is served; a green already in progress when the
    // request arrives is too short to be safe for a full WALK phase.
    assign w_grnRise = w_grn[g] & ~r_grnD;
    assign w_serve   = (r_state == ST_WAIT) && w_grnRise;

    // Request latch plus pedestrian FSM. The lamp outputs are registered here
    // so they change on the same edge as the state. The request clear on
    // service takes priority over a simultaneous press because that
    // pedestrian is about to get WALK anyway. Losing green in WALK or FLASH
    // cuts the phase short so pedestrians never see WALK against traffic.
    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
        r_state <= ST_IDLE;
        r_grnD  <= 1'b0;
        r_req   <= 1'b0;
        r_walk  <= 1'b0;
        r_flash <= 1'b0;
        r_phase <= '0;
        r_div   <= '0;
      end else begin
        r_grnD <= w_grn[g];

        if (w_serve) begin
          r_req <= 1'b0;
        end else if (w_press) begin
          r_req <= 1'b1;
        end

        case (r_state)
          ST_IDLE: begin
            if (r_req) begin
              r_state <= ST_WAIT;
              r_phase <= '0;
            end
          end
          ST_WAIT: begin
            if (w_grnRise) begin
              r_state <= ST_WALK;
              r_phase <= '0;
              r_walk  <= 1'b1;
            end
          end
          ST_WALK: begin
            if (!w_grn[g] || r_phase == WALK_LAST) begin
              r_state <= ST_FLASH;
              r_phase <= '0;
              r_div   <= '0;
              r_walk  <= 1'b0;
              r_flash <= 1'b1;
            end else begin
              r_phase <= r_phase + CNT_ONE;
            end
          end
          ST_FLASH: begin
            if (!w_grn[g] || r_phase == FLASH_LAST) begin
              r_state <= r_req ? ST_WAIT : ST_IDLE;
              r_phase <= '0;
              r_flash <= 1'b0;
            end else begin
              r_phase <= r_phase + CNT_ONE;
              if (r_div == DIV_LAST) begin
                r_div   <= '0;
                r_flash <= ~r_flash;
              end else begin
                r_div <= r_div + CNT_ONE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_walk  <= 1'b0;
            r_flash <= 1'b0;
          end
        endcase
      end
    end

    assign w_cross[g] = r_req;
    assign w_walk[g]  = r_walk;
    assign w_flash[g] = r_flash;

  end

endmodule

// File: tb/tb_crosswalk_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crosswalk_request_ctrl
// Directed bench for crosswalk_request_ctrl. Edge numbers in each scenario
// count from the first clock edge that samples the new button level; inputs
// change 1 time unit after an edge and outputs are read at that same point.
// ---------------------------------------------------------------------------
module tb_crosswalk_request_ctrl;

  logic clk;
  logic reset_n;
  int   nCompared;
  int   nMismatched;

  crosswalk_request_ctrl_if bus();

  crosswalk_request_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10-unit clock, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then step just past the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Quiet inputs, pulse reset, leave the bench 1 unit after an edge.
  task automatic resetDut();
    bus.btn_0 = 1'b0;
    bus.btn_1 = 1'b0;
    bus.grn_0 = 1'b0;
    bus.grn_1 = 1'b0;
    reset_n   = 1'b1;
    waitEdges(3);
    reset_n   = 1'b0;
    waitEdges(2);
  endtask

  // Outputs must all be zero while reset is held.
  task automatic test_reset();
    bus.btn_0 = 1'b1;
    bus.btn_1 = 1'b1;
    bus.grn_0 = 1'b1;
    bus.grn_1 = 1'b1;
    reset_n   = 1'b1;
    waitEdges(8);
    nCompared++;
    if ({bus.crosswalk_1, bus.crosswalk_0, bus.walk_1, bus.walk_0, bus.flash_1, bus.flash_0} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs got %b want 000000",
               {bus.crosswalk_1, bus.crosswalk_0, bus.walk_1, bus.walk_0, bus.flash_1, bus.flash_0});
    end
  endtask

  // Three-cycle pulse must be swallowed by the debouncer.
  task automatic test_glitch();
    resetDut();
    bus.btn_0 = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      waitEdges(1);
      nCompared++;
      if ({bus.crosswalk_0, bus.walk_0, bus.flash_0} !== 3'b000) begin
        nMismatched++;
        $display("[TB] FAIL glitch e=%0d {cross,walk,flash} got %b want 000", e,
                 {bus.crosswalk_0, bus.walk_0, bus.flash_0});
      end
      if (e == 2) bus.btn_0 = 1'b0;
      if (e == 8) bus.grn_0 = 1'b1;
    end
  endtask

  // A pulse of exactly DEB_CYCLES synchronised cycles is accepted.
  task automatic test_deb_boundary();
    resetDut();
    bus.btn_0 = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      waitEdges(1);
      nCompared++;
      if (bus.crosswalk_0 !== (e >= 6)) begin
        nMismatched++;
        $display("[TB] FAIL deb_boundary e=%0d crosswalk_0 got %b want %b", e, bus.crosswalk_0, (e >= 6));
      end
      if (e == 3) bus.btn_0 = 1'b0;
    end
  endtask

  // Full service: request, WALK for 12 cycles, flash pattern, back to idle.
  task automatic test_clean_press();
    logic expCross, expWalk, expFlash;
    resetDut();
    bus.btn_0 = 1'b1;
    for (int e = 0; e <= 44; e++) begin
      waitEdges(1);
      expCross = (e >= 6 && e <= 20);
      expWalk  = (e >= 21 && e <= 32);
      expFlash = (e >= 33 && e <= 38) && (((e - 33) / 2) % 2 == 0);
      nCompared++;
      if ({bus.crosswalk_0, bus.walk_0, bus.flash_0} !== {expCross, expWalk, expFlash}) begin
        nMismatched++;
        $display("[TB] FAIL clean_press e=%0d {cross,walk,flash} got %b want %b", e,
                 {bus.crosswalk_0, bus.walk_0, bus.flash_0}, {expCross, expWalk, expFlash});
      end
      if (e == 9)  bus.btn_0 = 1'b0;
      if (e == 20) bus.grn_0 = 1'b1;
    end
  endtask

  // Green drops after five WALK cycles: one flash cycle, then idle.
  task automatic test_early_green_loss();
    logic expCross, expWalk, expFlash;
    resetDut();
    bus.btn_0 = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      waitEdges(1);
      expCross = (e >= 6 && e <= 20);
      expWalk  = (e >= 21 && e <= 25);
      expFlash = (e == 26);
      nCompared++;
      if ({bus.crosswalk_0, bus.walk_0, bus.flash_0} !== {expCross, expWalk, expFlash}) begin
        nMismatched++;
        $display("[TB] FAIL early_green e=%0d {cross,walk,flash} got %b want %b", e,
                 {bus.crosswalk_0, bus.walk_0, bus.flash_0}, {expCross, expWalk, expFlash});
      end
      if (e == 9)  bus.btn_0 = 1'b0;
      if (e == 20) bus.grn_0 = 1'b1;
      if (e == 25) bus.grn_0 = 1'b0;
    end
  endtask

  // Green already on when the request lands: wait for the next rise.
  task automatic test_late_request();
    logic expCross, expWalk, expFlash;
    resetDut();
    bus.grn_1 = 1'b1;
    bus.btn_1 = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      waitEdges(1);
      expCross = (e >= 6 && e <= 24);
      expWalk  = (e >= 25 && e <= 36);
      expFlash = (e >= 37 && e <= 38);
      nCompared++;
      if ({bus.crosswalk_0, bus.crosswalk_1, bus.walk_1, bus.flash_1} !== {1'b0, expCross, expWalk, expFlash}) begin
        nMismatched++;
        $display("[TB] FAIL late_request e=%0d {cross0,cross1,walk1,flash1} got %b want %b", e,
                 {bus.crosswalk_0, bus.crosswalk_1, bus.walk_1, bus.flash_1},
                 {1'b0, expCross, expWalk, expFlash});
      end
      if (e == 9)  bus.btn_1 = 1'b0;
      if (e == 20) bus.grn_1 = 1'b0;
      if (e == 24) bus.grn_1 = 1'b1;
    end
  endtask

  // Press during WALK re-requests; channel 1 runs its own cycle meanwhile.
  task automatic test_back_to_back();
    logic [5:0] expVec;
    logic [5:0] gotVec;
    logic       c0, w0, f0, c1, w1, f1;
    resetDut();
    bus.btn_0 = 1'b1;
    bus.btn_1 = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      waitEdges(1);
      c0 = (e >= 6 && e <= 20) || (e >= 29 && e <= 44);
      w0 = (e >= 21 && e <= 32) || (e >= 45);
      f0 = (e >= 33 && e <= 38) && (((e - 33) / 2) % 2 == 0);
      c1 = (e >= 6 && e <= 14);
      w1 = (e >= 15 && e <= 26);
      f1 = (e >= 27 && e <= 32) && (((e - 27) / 2) % 2 == 0);
      expVec = {c0, w0, f0, c1, w1, f1};
      gotVec = {bus.crosswalk_0, bus.walk_0, bus.flash_0, bus.crosswalk_1, bus.walk_1, bus.flash_1};
      nCompared++;
      if (gotVec !== expVec) begin
        nMismatched++;
        $display("[TB] FAIL back_to_back e=%0d {c0,w0,f0,c1,w1,f1} got %b want %b", e, gotVec, expVec);
      end
      if (e == 9) begin
        bus.btn_0 = 1'b0;
        bus.btn_1 = 1'b0;
      end
      if (e == 14) bus.grn_1 = 1'b1;
      if (e == 20) bus.grn_0 = 1'b1;
      if (e == 22) bus.btn_0 = 1'b1;
      if (e == 28) bus.btn_0 = 1'b0;
      if (e == 40) bus.grn_0 = 1'b0;
      if (e == 44) bus.grn_0 = 1'b1;
    end
  endtask

  // Reset mid-WALK clears outputs without a clock edge and drops the request.
  task automatic test_async_reset();
    resetDut();
    bus.btn_0 = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      waitEdges(1);
      if (e == 9)  bus.btn_0 = 1'b0;
      if (e == 20) bus.grn_0 = 1'b1;
    end
    nCompared++;
    if (bus.walk_0 !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_prewalk walk_0 got %b want 1", bus.walk_0);
    end
    #2;
    reset_n = 1'b1;
    #1;
    nCompared++;
    if ({bus.crosswalk_1, bus.crosswalk_0, bus.walk_1, bus.walk_0, bus.flash_1, bus.flash_0} !== 6'b0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_immediate got %b want 000000",
               {bus.crosswalk_1, bus.crosswalk_0, bus.walk_1, bus.walk_0, bus.flash_1, bus.flash_0});
    end
    waitEdges(1);
    reset_n   = 1'b0;
    bus.grn_0 = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      waitEdges(1);
      nCompared++;
      if ({bus.crosswalk_0, bus.walk_0, bus.flash_0} !== 3'b000) begin
        nMismatched++;
        $display("[TB] FAIL async_reset_after e=%0d {cross,walk,flash} got %b want 000", e,
                 {bus.crosswalk_0, bus.walk_0, bus.flash_0});
      end
      if (e == 2) bus.grn_0 = 1'b1;
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    bus.btn_0   = 1'b0;
    bus.btn_1   = 1'b0;
    bus.grn_0   = 1'b0;
    bus.grn_1   = 1'b0;
    reset_n     = 1'b1;
    $display("[TB] starting crosswalk_request_ctrl bench");
    test_reset();
    test_glitch();
    test_deb_boundary();
    test_clean_press();
    test_early_green_loss();
    test_late_request();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
